// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the slave memory FSM state type.
package ahbl_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // IDLE doubles as the completing data-phase cycle of an OKAY transfer.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR1 = 2'd2,
      ERR2 = 2'd3
   } ahbl_slv_state_t;

endpackage

// File: rtl/ahbl_wstrb_dec.sv
// Byte-lane strobe decoder: transfer size and low address bits to a
// little-endian 4-bit write strobe.
module ahbl_wstrb_dec
   import ahbl_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr,
   output logic [3:0] strb
);

   // One lane for bytes, an aligned lane pair for halves, all lanes for words.
   always_comb begin
      strb = 4'b0000;
      case (size)
         HSIZE_BYTE: strb = 4'b0001 << addr;
         HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: strb = 4'b1111;
         default:    strb = 4'b0000;
      endcase
   end

endmodule

// File: rtl/ahbl_slave_mem.sv
// AHB-Lite slave memory: word-organised RAM with a fixed number of wait
// states per OKAY transfer and a two-cycle ERROR response for illegal accesses.
module ahbl_slave_mem
   import ahbl_pkg::*;
#(
   parameter int MEM_AW      = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESETN,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   ahbl_slv_state_t   state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic              write_q, write_d;
   logic [2:0]        size_q, size_d;
   logic [MEM_AW+1:0] addr_q, addr_d;

   logic [31:0] mem_q [0:(2**MEM_AW)-1];

   logic        accept;
   logic        acc_err;
   logic        complete;
   logic [3:0]  strb;
   logic [31:0] rd_word;
   logic        unused_ok;

   // HBURST and HTRANS[0] carry no information this slave needs.
   assign unused_ok = ^{HBURST, HTRANS[0]};

   assign accept  = HSEL & HREADY & HTRANS[1];
   assign acc_err = (|HADDR[31:MEM_AW+2])
                  | (HSIZE > HSIZE_WORD)
                  | ((HSIZE == HSIZE_HALF) & HADDR[0])
                  | ((HSIZE == HSIZE_WORD) & (|HADDR[1:0]));

   // An OKAY data phase completes in the cycle the FSM sits in IDLE with a pending transfer.
   assign complete = (state_q == IDLE) & pend_q;

   ahbl_wstrb_dec u_wstrb_dec (
      .size (size_q),
      .addr (addr_q[1:0]),
      .strb (strb)
   );

   // Next-state, wait counter and address-phase capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      write_d = write_q;
      size_d  = size_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE, ERR2: begin
            state_d = IDLE;
            pend_d  = 1'b0;
            if (accept) begin
               write_d = HWRITE;
               size_d  = HSIZE;
               addr_d  = HADDR[MEM_AW+1:0];
               if (acc_err) begin
                  state_d = ERR1;
               end else begin
                  pend_d = 1'b1;
                  if (WAIT_STATES > 0) begin
                     state_d = WAIT;
                     cnt_d   = WAIT_LOAD;
                  end
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         end
         ERR1: begin
            pend_d  = 1'b0;
            state_d = ERR2;
         end
         default: begin
            state_d = IDLE;
            pend_d  = 1'b0;
         end
      endcase
   end

   // Control and capture registers; reset drops any transfer in flight.
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         pend_q  <= 1'b0;
         write_q <= 1'b0;
         size_q  <= HSIZE_BYTE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         write_q <= write_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
      end
   end

   // RAM byte-lane write on the completing cycle; contents survive reset.
   always_ff @(posedge HCLK) begin
      for (int b = 0; b < 4; b++) begin
         if (complete && write_q && strb[b]) begin
            mem_q[addr_q[MEM_AW+1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   // The write commits at the edge closing its data phase, which is before any
   // read accepted in that same cycle completes, so the combinational read
   // already sees the freshly written bytes without a separate bypass.
   assign rd_word = mem_q[addr_q[MEM_AW+1:2]];

   // Bus outputs decoded from the FSM state; read data only on a read completion.
   always_comb begin
      HREADYOUT = (state_q == IDLE) || (state_q == ERR2);
      HRESP     = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      HRDATA    = (complete && !write_q) ? rd_word : 32'd0;
   end

endmodule

// File: tb/tb_ahbl_slave_mem.sv
// Bench for ahbl_slave_mem: two instances (zero and three wait states) on a
// shared bus, a driver issuing pipelined address phases, and a monitor that
// checks every data phase against an expected queue.
module tb_ahbl_slave_mem;

   localparam logic [1:0] T_IDLE   = 2'd0;
   localparam logic [1:0] T_NONSEQ = 2'd2;
   localparam logic [1:0] T_SEQ    = 2'd3;
   localparam logic [2:0] S_BYTE   = 3'd0;
   localparam logic [2:0] S_HALF   = 3'd1;
   localparam logic [2:0] S_WORD   = 3'd2;

   // ---------------- clock / reset ----------------
   logic hclk = 1'b0;
   logic hresetn;
   always #5 hclk = ~hclk;

   int cyc = 0;
   always @(posedge hclk) cyc <= cyc + 1;

   // ---------------- bus ----------------
   logic [1:0]  hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;
   logic        dsel;
   logic [1:0]  hreadyout;
   logic [1:0]  hresp;
   logic [31:0] hrdata [2];
   logic        hready_bus;

   assign hready_bus = hreadyout[dsel];

   ahbl_slave_mem #(.MEM_AW(10), .WAIT_STATES(0)) u_dut0 (
      .HCLK(hclk), .HRESETN(hresetn), .HSEL(hsel[0]), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HWDATA(hwdata), .HREADY(hready_bus), .HREADYOUT(hreadyout[0]),
      .HRESP(hresp[0]), .HRDATA(hrdata[0])
   );

   ahbl_slave_mem #(.MEM_AW(10), .WAIT_STATES(3)) u_dut1 (
      .HCLK(hclk), .HRESETN(hresetn), .HSEL(hsel[1]), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HWDATA(hwdata), .HREADY(hready_bus), .HREADYOUT(hreadyout[1]),
      .HRESP(hresp[1]), .HRDATA(hrdata[1])
   );

   // ---------------- scoreboard ----------------
   // entry: {dut, resp, low_cycles[3:0], rdata[31:0]}
   logic [37:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   logic        in_dp  [2];
   int          low_cnt[2];
   logic [37:0] cur    [2];

   // Monitor: samples at the falling edge, tracks each slave's data phase.
   always @(negedge hclk) begin
      for (int d = 0; d < 2; d++) begin
         if (!hresetn) begin
            in_dp[d] = 1'b0;
         end else begin
            if (in_dp[d]) begin
               if (!hreadyout[d]) begin
                  low_cnt[d]++;
                  check("low_resp", 40'(hresp[d]), 40'(cur[d][36]));
                  check("low_rdata", 40'(hrdata[d]), 40'd0);
                  if (low_cnt[d] > 20) begin
                     check("dp_timeout", 40'(low_cnt[d]), 40'(cur[d][35:32]));
                     in_dp[d] = 1'b0;
                  end
               end else begin
                  check("resp", 40'(hresp[d]), 40'(cur[d][36]));
                  check("wait_cycles", 40'(low_cnt[d]), 40'(cur[d][35:32]));
                  check("rdata", 40'(hrdata[d]), 40'(cur[d][31:0]));
                  in_dp[d] = 1'b0;
               end
            end else begin
               check("idle_out", {6'd0, hreadyout[d], hresp[d], hrdata[d]},
                     {6'd0, 1'b1, 1'b0, 32'd0});
            end
            if (hsel[d] && hready_bus && htrans[1]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_xfer: dut %0d accepted with no expectation queued", d);
               end else begin
                  cur[d] = exp_q.pop_front();
                  check("xfer_dut", 40'(cur[d][37]), 40'(d));
                  in_dp[d]   = 1'b1;
                  low_cnt[d] = 0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // One address phase; returns one step into the first data-phase cycle with
   // HWDATA driven for that beat.
   task automatic bus(input logic d, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                      input logic rsp, input logic [3:0] wt, input logic [31:0] rd);
      int n;
      dsel   = d;
      hsel   = 2'b01 << d;
      haddr  = addr;
      htrans = tr;
      hwrite = wr;
      hsize  = sz;
      if (tr[1]) exp_q.push_back({d, rsp, wt, rd});
      n = 0;
      while (1) begin
         @(negedge hclk);
         if (hready_bus) break;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: dut %0d never raised HREADYOUT", d);
            break;
         end
      end
      @(posedge hclk);
      #1;
      hwdata = wd;
   endtask

   task automatic wr(input logic d, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] data);
      bus(d, T_NONSEQ, 1'b1, sz, a, data, 1'b0, d ? 4'd3 : 4'd0, 32'd0);
   endtask

   task automatic rd(input logic d, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] data);
      bus(d, T_NONSEQ, 1'b0, sz, a, 32'd0, 1'b0, d ? 4'd3 : 4'd0, data);
   endtask

   task automatic bad(input logic d, input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] data);
      bus(d, T_NONSEQ, w, sz, a, data, 1'b1, 4'd1, 32'd0);
   endtask

   task automatic idle(input logic d);
      bus(d, T_IDLE, 1'b0, S_WORD, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   int c0;

   initial begin
      hresetn = 1'b0;
      hsel    = 2'b00;
      haddr   = 32'd0;
      htrans  = T_IDLE;
      hwrite  = 1'b0;
      hsize   = S_WORD;
      hburst  = 3'd0;
      hwdata  = 32'd0;
      dsel    = 1'b0;
      for (int d = 0; d < 2; d++) begin
         in_dp[d]   = 1'b0;
         low_cnt[d] = 0;
         cur[d]     = '0;
      end

      repeat (2) @(posedge hclk);
      #2;
      check("rst_out0", {6'd0, hreadyout[0], hresp[0], hrdata[0]}, {6'd0, 1'b1, 1'b0, 32'd0});
      check("rst_out1", {6'd0, hreadyout[1], hresp[1], hrdata[1]}, {6'd0, 1'b1, 1'b0, 32'd0});
      @(posedge hclk);
      #1;
      hresetn = 1'b1;
      @(posedge hclk);
      #1;

      // Pre-clear the word used by the lane test, then word write/read.
      wr(0, S_WORD, 32'h004, 32'h0000_0000);
      wr(0, S_WORD, 32'h000, 32'hDEAD_BEEF);
      rd(0, S_WORD, 32'h000, 32'hDEAD_BEEF);
      idle(0);

      // Byte lane 1 and upper half lanes, read back as full words.
      wr(0, S_BYTE, 32'h005, 32'h0000_AA00);
      wr(0, S_HALF, 32'h006, 32'h1234_0000);
      rd(0, S_WORD, 32'h004, 32'h1234_AA00);
      rd(0, S_BYTE, 32'h006, 32'h1234_AA00);
      idle(0);

      // Errors: misaligned word, out-of-range word, odd half, oversize; then a
      // read accepted during ERR2 shows word 0 untouched (no aliasing either).
      bad(0, 1'b1, S_WORD, 32'h002, 32'h1111_1111);
      bad(0, 1'b1, S_WORD, 32'h1000, 32'h2222_2222);
      bad(0, 1'b1, S_HALF, 32'h003, 32'h3333_3333);
      bad(0, 1'b0, 3'd3,   32'h000, 32'h0);
      rd(0, S_WORD, 32'h000, 32'hDEAD_BEEF);
      idle(0);

      // INCR4 write then read of the last beat: five address phases plus the
      // trailing read data phase take six cycles.
      c0 = cyc;
      hburst = 3'd3;
      bus(0, T_NONSEQ, 1'b1, S_WORD, 32'h010, 32'hA000_0001, 1'b0, 4'd0, 32'd0);
      bus(0, T_SEQ,    1'b1, S_WORD, 32'h014, 32'hA000_0002, 1'b0, 4'd0, 32'd0);
      bus(0, T_SEQ,    1'b1, S_WORD, 32'h018, 32'hA000_0003, 1'b0, 4'd0, 32'd0);
      bus(0, T_SEQ,    1'b1, S_WORD, 32'h01C, 32'hA000_0004, 1'b0, 4'd0, 32'd0);
      hburst = 3'd0;
      rd(0, S_WORD, 32'h01C, 32'hA000_0004);
      idle(0);
      check("b2b_cycles", 40'(cyc - c0), 40'd6);
      rd(0, S_WORD, 32'h010, 32'hA000_0001);
      idle(0);

      // Three wait states on the second slave.
      wr(1, S_WORD, 32'h040, 32'hCAFE_F00D);
      rd(1, S_WORD, 32'h040, 32'hCAFE_F00D);
      idle(1);

      // Reset during the wait of a write: outputs return at once, word kept.
      wr(1, S_WORD, 32'h080, 32'h5A5A_5A5A);
      idle(1);
      wr(1, S_WORD, 32'h080, 32'hFFFF_FFFF);
      htrans = T_IDLE;
      #1;
      hresetn = 1'b0;
      #1;
      check("rst_mid_out1", {6'd0, hreadyout[1], hresp[1], hrdata[1]}, {6'd0, 1'b1, 1'b0, 32'd0});
      check("rst_mid_out0", {6'd0, hreadyout[0], hresp[0], hrdata[0]}, {6'd0, 1'b1, 1'b0, 32'd0});
      repeat (2) @(posedge hclk);
      #1;
      hresetn = 1'b1;
      @(posedge hclk);
      #1;
      rd(1, S_WORD, 32'h080, 32'h5A5A_5A5A);
      idle(1);

      repeat (3) @(posedge hclk);
      check("queue_empty", 40'(exp_q.size()), 40'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
